// File: rtl/fpu_vector_checker.sv
// fpu_vector_checker: streams (operand, expected) vectors into a single-operand FPU unit and scores
// its results bit-exactly. Define FVC_ERR_CAPTURE_EN to latch the first failing vector.
module fpu_vector_checker #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_op,
  input  logic [WIDTH-1:0] s_exp,
  input  logic             s_last,
  output logic [WIDTH-1:0] dut_op,
  input  logic [WIDTH-1:0] dut_result,
  output logic             busy,
  output logic             done,
  output logic [31:0]      cnt_total,
  output logic [31:0]      cnt_fail,
  output logic [WIDTH-1:0] err_op,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             accept, clear, cmp_valid, mismatch, upstream_busy;
  logic [LATENCY:0] tag_v;
  logic [WIDTH-1:0] tag_exp [LATENCY+1];

  // Stream handshake: a beat transfers on any edge where s_valid && s_ready; s_ready is high
  // exactly while in RUN and does not depend on s_valid, so one beat can move every cycle.
  assign accept    = s_valid && s_ready;
  assign clear     = start && ((state == S_IDLE) || (state == S_DONE));
  assign cmp_valid = tag_v[LATENCY];
  assign mismatch  = cmp_valid && (dut_result != tag_exp[LATENCY]);

  // Any tag still behind the compare stage keeps the drain going.
  always_comb begin
    upstream_busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) upstream_busy = upstream_busy | tag_v[i];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (accept && s_last) state_nxt = S_DRAIN;
      S_DRAIN: if (cmp_valid && !upstream_busy) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready   = (state == S_RUN);
    busy      = (state == S_RUN) || (state == S_DRAIN);
    done      = (state == S_DONE);
    dbg_state = state;
  end

  // Operand register and tag shift register run in lockstep with the unit under test.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dut_op <= '0;
      tag_v  <= '0;
      for (int i = 0; i <= LATENCY; i++) tag_exp[i] <= '0;
    end else begin
      if (accept) begin
        dut_op     <= s_op;
        tag_exp[0] <= s_exp;
      end
      tag_v[0] <= accept;
      for (int i = 1; i <= LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_exp[i] <= tag_exp[i-1];
      end
    end
  end

  // Saturating statistics; a new run starts them from zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_total <= '0;
      cnt_fail  <= '0;
    end else if (clear) begin
      cnt_total <= '0;
      cnt_fail  <= '0;
    end else if (cmp_valid) begin
      if (cnt_total != 32'hFFFF_FFFF) cnt_total <= cnt_total + 32'd1;
      if (mismatch && (cnt_fail != 32'hFFFF_FFFF)) cnt_fail <= cnt_fail + 32'd1;
    end
  end

`ifdef FVC_ERR_CAPTURE_EN
  logic [WIDTH-1:0] tag_op [LATENCY+1];
  logic             err_seen;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i <= LATENCY; i++) tag_op[i] <= '0;
      err_seen <= 1'b0;
      err_op   <= '0;
      err_exp  <= '0;
      err_got  <= '0;
    end else begin
      if (accept) tag_op[0] <= s_op;
      for (int i = 1; i <= LATENCY; i++) tag_op[i] <= tag_op[i-1];
      if (clear) begin
        err_seen <= 1'b0;
        err_op   <= '0;
        err_exp  <= '0;
        err_got  <= '0;
      end else if (mismatch && !err_seen) begin
        err_seen <= 1'b1;
        err_op   <= tag_op[LATENCY];
        err_exp  <= tag_exp[LATENCY];
        err_got  <= dut_result;
      end
    end
  end
`else
  assign err_op  = '0;
  assign err_exp = '0;
  assign err_got = '0;
`endif

endmodule

// File: tb/tb_fpu_vector_checker.sv
// Bench for fpu_vector_checker: one checker per latency (0 and 3) driving fneg models, fed the
// same stream and scored every cycle against a transaction-level model of the run.
`timescale 1ns/1ps
module tb_fpu_vector_checker;
  localparam int W = 32;
  localparam logic [W-1:0] SIGN = 32'h8000_0000;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_DONE = 3;
  localparam int LAT [2] = '{0, 3};
`ifdef FVC_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [W-1:0] s_op = '0, s_exp = '0;
  logic         o_ready [2], o_busy [2], o_done [2];
  logic [W-1:0] o_dut_op [2], o_result [2], o_err_op [2], o_err_exp [2], o_err_got [2];
  logic [31:0]  o_total [2], o_fail [2];
  logic [1:0]   o_state [2];
  logic [W-1:0] p1, p2, p3;

  always #5 clk = ~clk;

  fpu_vector_checker #(.WIDTH(W), .LATENCY(0)) u0 (
    .clk(clk), .rstn(rstn), .start(start), .s_valid(s_valid), .s_ready(o_ready[0]),
    .s_op(s_op), .s_exp(s_exp), .s_last(s_last), .dut_op(o_dut_op[0]), .dut_result(o_result[0]),
    .busy(o_busy[0]), .done(o_done[0]), .cnt_total(o_total[0]), .cnt_fail(o_fail[0]),
    .err_op(o_err_op[0]), .err_exp(o_err_exp[0]), .err_got(o_err_got[0]), .dbg_state(o_state[0]));

  fpu_vector_checker #(.WIDTH(W), .LATENCY(3)) u3 (
    .clk(clk), .rstn(rstn), .start(start), .s_valid(s_valid), .s_ready(o_ready[1]),
    .s_op(s_op), .s_exp(s_exp), .s_last(s_last), .dut_op(o_dut_op[1]), .dut_result(o_result[1]),
    .busy(o_busy[1]), .done(o_done[1]), .cnt_total(o_total[1]), .cnt_fail(o_fail[1]),
    .err_op(o_err_op[1]), .err_exp(o_err_exp[1]), .err_got(o_err_got[1]), .dbg_state(o_state[1]));

  // Units under test: combinational fneg, and fneg behind three register stages.
  assign o_result[0] = o_dut_op[0] ^ SIGN;
  always @(posedge clk) begin
    p1 <= o_dut_op[1];
    p2 <= p1;
    p3 <= p2;
  end
  assign o_result[1] = p3 ^ SIGN;

  // ---------------- scoreboard / model ----------------
  typedef struct {
    int           due;
    logic [W-1:0] op;
    logic [W-1:0] exp;
  } ent_t;
  ent_t exp_q0[$];
  ent_t exp_q1[$];
  ent_t e_new;

  int           cyc = 0;
  int           m_phase [2];
  logic [31:0]  m_total [2], m_fail [2];
  logic [W-1:0] m_op [2], m_eop [2], m_eexp [2], m_egot [2];
  logic         m_eseen [2];
  logic         sat_req = 1'b0;
  logic         chk_en = 1'b0;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input int lat, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (latency %0d) at %0t: got %h expected %h", name, lat, $time, got, exp);
    end
  endtask

  function automatic void clear_stats(int k);
    m_total[k] = '0;
    m_fail[k]  = '0;
    m_eseen[k] = 1'b0;
    m_eop[k]   = '0;
    m_eexp[k]  = '0;
    m_egot[k]  = '0;
  endfunction

  // One vector leaves the pipeline: the unit negates it, the checker scores it.
  function automatic void score(int k, logic [W-1:0] op, logic [W-1:0] exp);
    logic [W-1:0] got;
    got = op ^ SIGN;
    if (m_total[k] != 32'hFFFF_FFFF) m_total[k] = m_total[k] + 32'd1;
    if (got != exp) begin
      if (m_fail[k] != 32'hFFFF_FFFF) m_fail[k] = m_fail[k] + 32'd1;
      if (!m_eseen[k]) begin
        m_eseen[k] = 1'b1;
        m_eop[k]   = op;
        m_eexp[k]  = exp;
        m_egot[k]  = got;
      end
    end
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q0.delete();
      exp_q1.delete();
      for (int k = 0; k < 2; k++) begin
        m_phase[k] = PH_IDLE;
        m_op[k]    = '0;
        clear_stats(k);
      end
    end else begin
      cyc++;
      if (sat_req) for (int k = 0; k < 2; k++) m_total[k] = 32'hFFFF_FFFE;
      while (exp_q0.size() > 0 && exp_q0[0].due == cyc) begin
        score(0, exp_q0[0].op, exp_q0[0].exp);
        void'(exp_q0.pop_front());
      end
      while (exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
        score(1, exp_q1[0].op, exp_q1[0].exp);
        void'(exp_q1.pop_front());
      end
      for (int k = 0; k < 2; k++) begin
        case (m_phase[k])
          PH_RUN: if (s_valid) begin
            e_new.due = cyc + 1 + LAT[k];
            e_new.op  = s_op;
            e_new.exp = s_exp;
            if (k == 0) exp_q0.push_back(e_new);
            else        exp_q1.push_back(e_new);
            m_op[k] = s_op;
            if (s_last) m_phase[k] = PH_DRAIN;
          end
          PH_DRAIN: if (((k == 0) ? exp_q0.size() : exp_q1.size()) == 0) m_phase[k] = PH_DONE;
          default: if (start) begin
            clear_stats(k);
            m_phase[k] = PH_RUN;
          end
        endcase
      end
    end
  end

  // Compare every output of both checkers against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("s_ready",   LAT[k], 32'(o_ready[k]), 32'(m_phase[k] == PH_RUN));
        chk("busy",      LAT[k], 32'(o_busy[k]),  32'(m_phase[k] == PH_RUN || m_phase[k] == PH_DRAIN));
        chk("done",      LAT[k], 32'(o_done[k]),  32'(m_phase[k] == PH_DONE));
        chk("state",     LAT[k], 32'(o_state[k]), 32'(m_phase[k]));
        chk("dut_op",    LAT[k], o_dut_op[k],     m_op[k]);
        chk("cnt_total", LAT[k], o_total[k],      m_total[k]);
        chk("cnt_fail",  LAT[k], o_fail[k],       m_fail[k]);
        chk("err_op",    LAT[k], o_err_op[k],     CAP ? m_eop[k]  : '0);
        chk("err_exp",   LAT[k], o_err_exp[k],    CAP ? m_eexp[k] : '0);
        chk("err_got",   LAT[k], o_err_got[k],    CAP ? m_egot[k] : '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] op, input logic [W-1:0] exp, input logic last);
    s_valid = 1'b1;
    s_op    = op;
    s_exp   = exp;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (o_done[0] && o_done[1]) break;
      tick();
    end
    chk("done_wait", 3, {30'd0, o_done[1], o_done[0]}, 32'd3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sent;
    int n;
    logic [W-1:0] op;

    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_total", 3, o_total[1], 32'd0);
    chk("reset_state", 3, 32'(o_state[1]), 32'd0);
    rstn = 1'b1;
    tick();

    // fneg golden pair
    pulse_start();
    send(32'h0000_0000, 32'h8000_0000, 1'b0);
    send(32'h3F80_0000, 32'hBF80_0000, 1'b1);
    chk("done_before_compare", 0, 32'(o_done[0]), 32'd0);
    tick();
    chk("done_two_cycles", 0, 32'(o_done[0]), 32'd1);
    chk("pair_total", 0, o_total[0], 32'd2);
    chk("pair_fail", 0, o_fail[0], 32'd0);
    wait_done(20);
    chk("pair_total", 3, o_total[1], 32'd2);
    chk("pair_fail", 3, o_fail[1], 32'd0);

    // two wrong expectations
    pulse_start();
    send(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    send(32'hC000_0000, 32'h0000_0000, 1'b1);
    wait_done(20);
    for (int k = 0; k < 2; k++) begin
      chk("fault_fail", LAT[k], o_fail[k], 32'd2);
      chk("fault_err_op", LAT[k], o_err_op[k], CAP ? 32'h3F80_0000 : 32'h0);
      chk("fault_err_exp", LAT[k], o_err_exp[k], CAP ? 32'h3F80_0000 : 32'h0);
      chk("fault_err_got", LAT[k], o_err_got[k], CAP ? 32'hBF80_0000 : 32'h0);
    end

    // 10000 back-to-back correct vectors
    pulse_start();
    for (int i = 0; i < 10000; i++) begin
      op      = $urandom;
      s_valid = 1'b1;
      s_op    = op;
      s_exp   = op ^ SIGN;
      s_last  = (i == 9999);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    wait_done(20);
    for (int k = 0; k < 2; k++) begin
      chk("bulk_total", LAT[k], o_total[k], 32'd10000);
      chk("bulk_fail", LAT[k], o_fail[k], 32'd0);
    end

    // random gaps, stray start pulses, some wrong expectations
    pulse_start();
    n = 300;
    sent = 0;
    while (sent < n) begin
      s_valid = ($urandom_range(0, 2) != 0);
      start   = ($urandom_range(0, 30) == 0);
      op      = $urandom;
      s_op    = op;
      s_exp   = ($urandom_range(0, 7) == 0) ? $urandom : (op ^ SIGN);
      s_last  = s_valid && (sent == n - 1);
      tick();
      if (s_valid) sent++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
    wait_done(20);
    for (int k = 0; k < 2; k++) chk("gap_total", LAT[k], o_total[k], 32'd300);

    // reset with three vectors in flight
    pulse_start();
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0);
    rstn = 1'b0;
    tick();
    chk("midrun_reset_state", 3, 32'(o_state[1]), 32'd0);
    chk("midrun_reset_total", 3, o_total[1], 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    tick();
    tick();
    chk("after_reset_total", 3, o_total[1], 32'd0);
    chk("after_reset_state", 3, 32'(o_state[1]), 32'd0);

    // saturation of the vector counter
    pulse_start();
    @(negedge clk);
    #1;
    force u0.cnt_total = 32'hFFFF_FFFE;
    force u3.cnt_total = 32'hFFFF_FFFE;
    sat_req = 1'b1;
    @(posedge clk);
    #1;
    release u0.cnt_total;
    release u3.cnt_total;
    sat_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op = $urandom;
      send(op, op ^ SIGN, i == 2);
    end
    wait_done(20);
    for (int k = 0; k < 2; k++) chk("saturated_total", LAT[k], o_total[k], 32'hFFFF_FFFF);

    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_vector_checker.md
# fpu_vector_checker

Hardware-side consumer of FPU sample vectors, the reading end of the sample-dump flow. It accepts (operand, expected-result) pairs over a valid/ready stream and drives each operand into a single-operand FPU unit under test. It compares the unit's result, bit-exact, against the expected value and keeps pass/fail statistics. It sits between the vector loader (ROM or UART receiver) and any one-input FPU block (fneg, fabs, fsqrt, ...) for on-board regression.

## Interface
- `WIDTH`, 32: operand/result width in bits.
- `LATENCY`, 0: pipeline depth of the unit under test in cycles. Legal range is 0..7.

- `clk`  in  1  clock
- `rstn`  in  1  reset; asynchronous, active-low
- `start`  in  1  one-cycle pulse: clear statistics and begin a run
- `s_valid`  in  1  vector beat valid
- `s_ready`  out  1  checker can accept a beat
- `s_op`  in  WIDTH  operand
- `s_exp`  in  WIDTH  expected result
- `s_last`  in  1  beat is the final vector of the run
- `dut_op`  out  WIDTH  operand to the unit under test (registered)
- `dut_result`  in  WIDTH  unit-under-test result
- `busy`  out  1  run or drain in progress
- `done`  out  1  run complete; held until next `start`
- `cnt_total`  out  32  vectors compared
- `cnt_fail`  out  32  mismatching vectors
- `err_op`, `err_exp`, `err_got`  out  WIDTH each  first failing vector (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: entered at reset. `start` moves to RUN.
  - RUN: beats are accepted. An accepted beat with `s_last`=1 moves to DRAIN.
  - DRAIN: wait until the in-flight pipeline is empty, then move to DONE.
  - DONE: `start` moves to RUN.
- `start` in IDLE or DONE clears `cnt_total`, `cnt_fail`, `done` and the error capture registers. `start` in RUN or DRAIN is ignored.
- `s_ready` = 1 only in RUN. A beat is accepted when `s_valid` && `s_ready`. Throughput is one vector per cycle; gaps in `s_valid` are allowed.
- Each accepted beat is tracked by a tag (valid, exp, op). The tag travels through a shift register of depth `LATENCY`+1 alongside the unit under test.
- Compare when the tag reaches the end of the shift register: mismatch = (`dut_result` != tag.exp), compared on all WIDTH bits. NaN payloads are not treated specially.
- `cnt_total` increments once per compared vector. `cnt_fail` increments once per mismatch. Both counters saturate at 0xFFFFFFFF.
- `busy` = 1 in RUN or DRAIN.

## Timing
- Reset values:
  - `s_ready`=0, `busy`=0, `done`=0
  - `dut_op`=0
  - `cnt_total`=0, `cnt_fail`=0
  - `err_*`=0
  - all tags invalid
- A beat accepted at edge t appears on `dut_op` after edge t (that is, during cycle t+1).
- `dut_result` for that beat is sampled at edge t+1+`LATENCY`. The counters reflect it after that edge.
- `dut_op` holds its last value when no beat is accepted.
- DRAIN → DONE happens on the edge on which the last valid tag is compared. `done` rises after that edge.
  - With `LATENCY`=0, `s_last` accepted at edge t gives `done`=1 after edge t+1.
- A `start` pulse coinciding with the DONE transition is ignored; `start` must arrive while in DONE.
- When `rstn` is asserted mid-run, all state clears immediately. In-flight tags are discarded without being counted.

## Configuration
- `FVC_ERR_CAPTURE_EN` defined:
  - On the first mismatch since `start`, latch tag.op into `err_op`, tag.exp into `err_exp` and `dut_result` into `err_got`.
  - Later mismatches do not overwrite these registers.
- `FVC_ERR_CAPTURE_EN` undefined:
  - The capture registers are not built.
  - `err_op`, `err_exp`, `err_got` are tied to 0.

## Test plan
- Unit under test = fneg, `LATENCY`=0. Stream op 0x00000000/exp 0x80000000, then op 0x3F800000/exp 0xBF800000 with `s_last`. Required: `cnt_total`=2, `cnt_fail`=0, `done`=1 two cycles after the last beat.
- Fault injection: send op 0x3F800000/exp 0x3F800000 (wrong), then op 0xC0000000/exp 0x00000000 (wrong). Required: `cnt_fail`=2; with the macro, `err_op`=0x3F800000, `err_exp`=0x3F800000, `err_got`=0xBF800000.
- Set `LATENCY`=3 with a 3-stage delayed fneg model. Send 10000 random ops with correct expected values, back-to-back. Required: `cnt_total`=10000, `cnt_fail`=0, `s_ready` low during the 4-cycle drain.
- Drive random `s_valid` gaps and a `start` pulse mid-RUN. Required: `start` is ignored, no beat is lost or duplicated, and the counters match the number of accepted beats.
- Assert `rstn` low while 3 beats are in flight (`LATENCY`=3). Required: all outputs return to their reset values, the state is IDLE, and `cnt_total`=0 after release.
- Force `cnt_total` to 0xFFFFFFFE via the bench, then compare 3 vectors. Required: `cnt_total`=0xFFFFFFFF with no wrap-around.
